// File: rtl/urv_mdu_pkg.sv
// Shared definitions for the uRV multiply/divide unit: funct3 codes, FSM states
// and operand-signedness helpers.
package urv_mdu_pkg;

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_RUN  = 2'd1,
        MDU_FIX  = 2'd2,
        MDU_DONE = 2'd3
    } mdu_state_t;

    // MUL is treated as unsigned: its low product half does not depend on signedness.
    function automatic logic rs1_signed(input logic [2:0] fun);
        return (fun == MDU_MULH) || (fun == MDU_MULHSU) || (fun == MDU_DIV) || (fun == MDU_REM);
    endfunction

    function automatic logic rs2_signed(input logic [2:0] fun);
        return (fun == MDU_MULH) || (fun == MDU_DIV) || (fun == MDU_REM);
    endfunction

endpackage

// File: rtl/urv_mdu_step.sv
// Combinational radix-2^g_bits_per_cycle step: restoring division or shift-add
// multiplication on a {hi, lo} register pair.
module urv_mdu_step #(
    parameter int g_xlen           = 32,
    parameter int g_bits_per_cycle = 1
) (
    input  logic              i_is_div,
    input  logic [g_xlen:0]   i_hi,
    input  logic [g_xlen-1:0] i_lo,
    input  logic [g_xlen-1:0] i_op,
    output logic [g_xlen:0]   o_hi,
    output logic [g_xlen-1:0] o_lo
);

    logic [g_xlen:0]   w_hi;
    logic [g_xlen:0]   w_sh;
    logic [g_xlen:0]   w_sum;
    logic [g_xlen-1:0] w_lo;

    // Divide: hi = partial remainder, lo = dividend shifting out / quotient shifting in.
    // Multiply: hi = accumulator, lo = multiplier shifting out / product low half shifting in.
    always_comb begin
        w_hi  = i_hi;
        w_lo  = i_lo;
        w_sh  = '0;
        w_sum = '0;
        for (int i = 0; i < g_bits_per_cycle; i++) begin
            if (i_is_div) begin
                w_sh = {w_hi[g_xlen-1:0], w_lo[g_xlen-1]};
                w_lo = {w_lo[g_xlen-2:0], 1'b0};
                if (w_sh >= {1'b0, i_op}) begin
                    w_hi    = w_sh - {1'b0, i_op};
                    w_lo[0] = 1'b1;
                end else begin
                    w_hi = w_sh;
                end
            end else begin
                w_sum = w_hi + (w_lo[0] ? {1'b0, i_op} : '0);
                w_hi  = {1'b0, w_sum[g_xlen:1]};
                w_lo  = {w_sum[0], w_lo[g_xlen-1:1]};
            end
        end
        o_hi = w_hi;
        o_lo = w_lo;
    end

endmodule

// File: rtl/urv_mdu.sv
// Iterative multiply/divide unit for the uRV execute stage.
// Optional divide result cache: define URV_MDU_OPERAND_CACHE_EN.
//
// state | meaning
// IDLE  | waiting for a MUL*/DIV*/REM* in X; accept raises x_stall_req_o
// RUN   | g_bits_per_cycle engine steps per cycle, counter down to 0
// FIX   | apply signs, pick result half, load x_rd_o
// DONE  | result valid, waits for x_stall_i=0 to be consumed
module urv_mdu
    import urv_mdu_pkg::*;
#(
    parameter int g_xlen           = 32,
    parameter int g_bits_per_cycle = 1,
    parameter int g_with_mulh      = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              x_stall_i,
    input  logic              x_kill_i,
    input  logic              d_valid_i,
    input  logic              d_is_multiply_i,
    input  logic              d_is_divide_i,
    input  logic [2:0]        d_fun_i,
    input  logic [g_xlen-1:0] d_rs1_i,
    input  logic [g_xlen-1:0] d_rs2_i,
    output logic              x_stall_req_o,
    output logic              x_busy_o,
    output logic [g_xlen-1:0] x_rd_o,
    output logic              x_done_o
);

    localparam int N  = g_xlen / g_bits_per_cycle;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]     CNT_INIT = CW'(N - 1);
    localparam logic [g_xlen-1:0] MOST_NEG = {1'b1, {(g_xlen-1){1'b0}}};

    mdu_state_t        r_state, w_next;
    logic [g_xlen:0]   r_hi;
    logic [g_xlen-1:0] r_lo;
    logic [g_xlen-1:0] r_op;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_fun;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [g_xlen-1:0] r_rd;
    logic              r_busy;
    logic              r_done;

    logic              w_accept, w_s1, w_s2, w_div0, w_ovf, w_special, w_hit;
    logic [g_xlen-1:0] w_abs1, w_abs2, w_special_rd, w_hit_rd, w_quo, w_rem, w_fix_rd;
    logic [2*g_xlen-1:0] w_prod, w_prod_s;
    logic [g_xlen:0]   w_step_hi;
    logic [g_xlen-1:0] w_step_lo;

    assign w_accept = (r_state == MDU_IDLE) & d_valid_i & (d_is_multiply_i | d_is_divide_i)
                    & ~x_kill_i & ~x_stall_i;
    assign w_s1     = rs1_signed(d_fun_i) & d_rs1_i[g_xlen-1];
    assign w_s2     = rs2_signed(d_fun_i) & d_rs2_i[g_xlen-1];
    assign w_abs1   = w_s1 ? -d_rs1_i : d_rs1_i;
    assign w_abs2   = w_s2 ? -d_rs2_i : d_rs2_i;
    assign w_div0   = d_is_divide_i & (d_rs2_i == '0);
    assign w_ovf    = d_is_divide_i & ~d_fun_i[0] & (d_rs1_i == MOST_NEG) & (&d_rs2_i);

`ifdef URV_MDU_OPERAND_CACHE_EN
    logic              r_c_valid, r_c_signed;
    logic [g_xlen-1:0] r_c_rs1, r_c_rs2, r_c_quo, r_c_rem, r_rs1, r_rs2;

    assign w_hit    = r_c_valid & d_is_divide_i & (d_rs1_i == r_c_rs1) & (d_rs2_i == r_c_rs2)
                    & (~d_fun_i[0] == r_c_signed);
    assign w_hit_rd = d_fun_i[1] ? r_c_rem : r_c_quo;
`else
    assign w_hit    = 1'b0;
    assign w_hit_rd = '0;
`endif

    assign w_special = w_hit | w_div0 | w_ovf;

    always_comb begin
        w_special_rd = '0;
        if (w_hit)
            w_special_rd = w_hit_rd;
        else if (w_div0)
            w_special_rd = d_fun_i[1] ? d_rs1_i : '1;
        else if (w_ovf)
            w_special_rd = d_fun_i[1] ? '0 : d_rs1_i;
    end

    urv_mdu_step #(
        .g_xlen           (g_xlen),
        .g_bits_per_cycle (g_bits_per_cycle)
    ) u_step (
        .i_is_div (r_fun[2]),
        .i_hi     (r_hi),
        .i_lo     (r_lo),
        .i_op     (r_op),
        .o_hi     (w_step_hi),
        .o_lo     (w_step_lo)
    );

    assign w_prod   = {r_hi[g_xlen-1:0], r_lo};
    assign w_prod_s = r_neg_q ? -w_prod : w_prod;
    assign w_quo    = r_neg_q ? -r_lo : r_lo;
    assign w_rem    = r_neg_r ? -r_hi[g_xlen-1:0] : r_hi[g_xlen-1:0];

    always_comb begin
        w_fix_rd = '0;
        case (r_fun)
            MDU_MUL:                         w_fix_rd = w_prod_s[g_xlen-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: w_fix_rd = (g_with_mulh != 0) ? w_prod_s[2*g_xlen-1:g_xlen] : '0;
            MDU_DIV, MDU_DIVU:               w_fix_rd = w_quo;
            default:                         w_fix_rd = w_rem;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            MDU_IDLE: if (w_accept) w_next = (d_is_divide_i & w_special) ? MDU_DONE : MDU_RUN;
            MDU_RUN:  if (r_cnt == '0) w_next = MDU_FIX;
            MDU_FIX:  w_next = MDU_DONE;
            MDU_DONE: if (~x_stall_i) w_next = MDU_IDLE;
            default:  w_next = MDU_IDLE;
        endcase
        if (x_kill_i)
            w_next = MDU_IDLE;
    end

    assign x_stall_req_o = ~x_kill_i & (w_accept | (r_state == MDU_RUN) | (r_state == MDU_FIX));
    assign x_busy_o      = r_busy;
    assign x_done_o      = r_done;
    assign x_rd_o        = r_rd;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= MDU_IDLE;
            r_hi    <= '0;
            r_lo    <= '0;
            r_op    <= '0;
            r_cnt   <= '0;
            r_fun   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_rd    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != MDU_IDLE);
            r_done  <= (w_next == MDU_DONE);
            case (r_state)
                MDU_IDLE: if (w_accept) begin
                    r_fun   <= d_fun_i;
                    r_neg_q <= w_s1 ^ w_s2;
                    r_neg_r <= w_s1;
                    r_op    <= w_abs2;
                    r_hi    <= '0;
                    r_lo    <= w_abs1;
                    r_cnt   <= CNT_INIT;
                    if (d_is_divide_i & w_special)
                        r_rd <= w_special_rd;
                end
                MDU_RUN: begin
                    r_hi  <= w_step_hi;
                    r_lo  <= w_step_lo;
                    r_cnt <= r_cnt - CW'(1);
                end
                MDU_FIX: if (~x_kill_i) r_rd <= w_fix_rd;
                default: ;
            endcase
        end
    end

`ifdef URV_MDU_OPERAND_CACHE_EN
    // Cache is refreshed whenever a divide reaches DONE, special cases included.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_c_valid  <= 1'b0;
            r_c_signed <= 1'b0;
            r_c_rs1    <= '0;
            r_c_rs2    <= '0;
            r_c_quo    <= '0;
            r_c_rem    <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
        end else if (r_state == MDU_RUN && x_kill_i) begin
            r_c_valid <= 1'b0;
        end else if (w_accept & d_is_divide_i) begin
            r_rs1 <= d_rs1_i;
            r_rs2 <= d_rs2_i;
            if (~w_hit & (w_div0 | w_ovf)) begin
                r_c_valid  <= 1'b1;
                r_c_signed <= ~d_fun_i[0];
                r_c_rs1    <= d_rs1_i;
                r_c_rs2    <= d_rs2_i;
                r_c_quo    <= w_div0 ? '1 : d_rs1_i;
                r_c_rem    <= w_div0 ? d_rs1_i : '0;
            end
        end else if (r_state == MDU_FIX && r_fun[2] && ~x_kill_i) begin
            r_c_valid  <= 1'b1;
            r_c_signed <= ~r_fun[0];
            r_c_rs1    <= r_rs1;
            r_c_rs2    <= r_rs2;
            r_c_quo    <= w_quo;
            r_c_rem    <= w_rem;
        end
    end
`endif

endmodule

// File: tb/tb_urv_mdu.sv
// Self-checking bench for urv_mdu (XLEN=32, 1 bit/cycle): directed cases plus
// random operations against an arithmetic reference model.
module tb_urv_mdu;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        x_stall_i = 1'b0;
    logic        x_kill_i = 1'b0;
    logic        d_valid_i = 1'b0;
    logic        d_is_multiply_i = 1'b0;
    logic        d_is_divide_i = 1'b0;
    logic [2:0]  d_fun_i = 3'b000;
    logic [31:0] d_rs1_i = '0;
    logic [31:0] d_rs2_i = '0;
    logic        x_stall_req_o, x_busy_o, x_done_o;
    logic [31:0] x_rd_o;

    int n_checks = 0;
    int n_fail   = 0;

    bit          c_valid = 1'b0;
    bit          c_signed = 1'b0;
    logic [31:0] c_a = '0, c_b = '0;

    logic [31:0] last_a = 32'd100, last_b = 32'd7;

    urv_mdu dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .x_stall_i       (x_stall_i),
        .x_kill_i        (x_kill_i),
        .d_valid_i       (d_valid_i),
        .d_is_multiply_i (d_is_multiply_i),
        .d_is_divide_i   (d_is_divide_i),
        .d_fun_i         (d_fun_i),
        .d_rs1_i         (d_rs1_i),
        .d_rs2_i         (d_rs2_i),
        .x_stall_req_o   (x_stall_req_o),
        .x_busy_o        (x_busy_o),
        .x_rd_o          (x_rd_o),
        .x_done_o        (x_done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] fun, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] ps;
        logic        [63:0] pu;
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        case (fun)
            3'b000: begin pu = {32'b0, a} * {32'b0, b}; return pu[31:0]; end
            3'b001: begin ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return ps[63:32]; end
            3'b010: begin ps = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return ps[63:32]; end
            3'b011: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_stall(input logic [2:0] fun, input logic [31:0] a, input logic [31:0] b);
        if (!fun[2]) return 34;
`ifdef URV_MDU_OPERAND_CACHE_EN
        if (c_valid && a == c_a && b == c_b && c_signed == !fun[0]) return 1;
`endif
        if (b == 0) return 1;
        if (!fun[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    task automatic run_op(input string tag, input logic [2:0] fun, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        logic [31:0] exp_rd;
        int exp_st, cnt;
        bit got;
        exp_rd = ref_result(fun, a, b);
        exp_st = ref_stall(fun, a, b);
        d_valid_i = 1'b1; d_is_multiply_i = ~fun[2]; d_is_divide_i = fun[2];
        d_fun_i = fun; d_rs1_i = a; d_rs2_i = b;
        cnt = 0; got = 1'b0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (x_done_o) begin got = 1'b1; break; end
            if (x_stall_req_o) cnt++;
            @(negedge clk_i);
        end
        check({tag, " done"}, 64'(got), 64'd1);
        check({tag, " rd"}, 64'(x_rd_o), 64'(exp_rd));
        check({tag, " stall"}, 64'(cnt), 64'(exp_st));
        if (hold > 0) begin
            x_stall_i = 1'b1;
            d_valid_i = 1'b0;
            repeat (hold) @(negedge clk_i);
            #1;
            check({tag, " held done"}, 64'(x_done_o), 64'd1);
            check({tag, " held rd"}, 64'(x_rd_o), 64'(exp_rd));
            x_stall_i = 1'b0;
        end
        d_valid_i = 1'b0;
        if (fun[2]) begin
            c_valid = 1'b1; c_a = a; c_b = b; c_signed = !fun[0];
        end
        @(negedge clk_i);
        #1;
        check({tag, " idle"}, 64'(x_busy_o), 64'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int done_seen, stall_seen;
        logic [2:0] f;
        logic [31:0] a, b;

        repeat (2) @(negedge clk_i);
        #1;
        check("reset busy", 64'(x_busy_o), 64'd0);
        check("reset done", 64'(x_done_o), 64'd0);
        check("reset rd", 64'(x_rd_o), 64'd0);
        check("reset stall", 64'(x_stall_req_o), 64'd0);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        run_op("divu", 3'b101, 32'd100, 32'd7, 0);
        run_op("remu", 3'b111, 32'd100, 32'd7, 0);
        run_op("div neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("rem neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 2);
        run_op("divu by0", 3'b101, 32'd5, 32'd0, 0);
        run_op("div ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("rem ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mul", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 0);
        run_op("mulh minmin", 3'b001, 32'h8000_0000, 32'h8000_0000, 0);

        // External stall in IDLE must block acceptance
        d_valid_i = 1'b1; d_is_multiply_i = 1'b1; d_is_divide_i = 1'b0;
        d_fun_i = 3'b000; d_rs1_i = 32'd6; d_rs2_i = 32'd7; x_stall_i = 1'b1;
        stall_seen = 0;
        repeat (3) begin
            #1;
            if (x_stall_req_o || x_busy_o) stall_seen++;
            @(negedge clk_i);
        end
        check("no accept under stall", 64'(stall_seen), 64'd0);
        x_stall_i = 1'b0;
        run_op("mul after stall", 3'b000, 32'd6, 32'd7, 0);

        // Kill in the 10th RUN cycle
        d_valid_i = 1'b1; d_is_multiply_i = 1'b0; d_is_divide_i = 1'b1;
        d_fun_i = 3'b101; d_rs1_i = 32'd1000; d_rs2_i = 32'd3;
        repeat (10) @(negedge clk_i);
        x_kill_i = 1'b1; d_valid_i = 1'b0;
        #1;
        check("kill busy before", 64'(x_busy_o), 64'd1);
        check("kill stall comb", 64'(x_stall_req_o), 64'd0);
        @(negedge clk_i);
        x_kill_i = 1'b0;
        c_valid = 1'b0;
        #1;
        check("kill idle", 64'(x_busy_o), 64'd0);
        done_seen = 0;
        repeat (40) begin
            @(negedge clk_i);
            #1;
            if (x_done_o) done_seen++;
        end
        check("kill no done", 64'(done_seen), 64'd0);
        run_op("mul after kill", 3'b000, 32'd3, 32'd4, 0);

        // Divide result reuse, then again with a reset in between
        run_op("cache div", 3'b100, 32'd100, 32'd7, 0);
        run_op("cache rem", 3'b110, 32'd100, 32'd7, 0);
        run_op("cache div2", 3'b100, 32'd100, 32'd7, 0);
        #2 rst_n_i = 1'b0;
        c_valid = 1'b0;
        #1;
        check("pulse reset busy", 64'(x_busy_o), 64'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        run_op("rem after reset", 3'b110, 32'd100, 32'd7, 0);

        // Asynchronous reset in the middle of a divide
        d_valid_i = 1'b1; d_is_multiply_i = 1'b0; d_is_divide_i = 1'b1;
        d_fun_i = 3'b100; d_rs1_i = 32'd12345; d_rs2_i = 32'd17;
        repeat (5) @(negedge clk_i);
        d_valid_i = 1'b0;
        #2 rst_n_i = 1'b0;
        c_valid = 1'b0;
        #1;
        check("midop reset busy", 64'(x_busy_o), 64'd0);
        check("midop reset stall", 64'(x_stall_req_o), 64'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom_range(0, 7));
            if (f[2] && $urandom_range(0, 3) == 0) begin
                a = last_a; b = last_b;
            end else begin
                a = pick_operand(); b = pick_operand();
            end
            if (f[2]) begin last_a = a; last_b = b; end
            run_op("rand", f, a, b, $urandom_range(0, 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
